// File: rtl/bh1750_emul_param_if.sv
// Open-drain I2C pin bundle between a bus model (master side) and the BH1750 emulator (slave side).
interface bh1750_emul_param_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;
  logic scl_oe;

  modport master (output scl_i, output sda_i, input sda_oe, input scl_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe, output scl_oe);
endinterface

// File: rtl/bh1750_emul_param.sv
// BH1750-style I2C light-sensor slave, oversampling SCL/SDA on system_clock.
// Define BH1750_CLK_STRETCH_EN to stretch SCL on reads issued before the first conversion completes.
module bh1750_emul_param #(
  parameter logic [6:0] DEV_ADDR    = 7'h23,
  parameter int         RD_BYTES    = 2,
  parameter int         MEAS_CYCLES = 1000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  system_clock,
  input  logic                  reset,
  bh1750_emul_param_if.slave    bus,
  input  logic [8*RD_BYTES-1:0] meas_value,
  output logic [8*RD_BYTES-1:0] result,
  output logic                  data_valid,
  output logic                  powered,
  output logic [7:0]            last_cmd,
  output logic                  addr_hit
);
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_MACK, S_IGNORE
  } state_t;

  localparam int            TW         = (MEAS_CYCLES > 1) ? $clog2(MEAS_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEAS_CYCLES - 1);
  localparam logic [1:0]    LAST_IDX   = 2'(RD_BYTES - 1);
  localparam int            RW         = 8 * RD_BYTES;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_q, shift_d;
  logic                   byte_done_q, byte_done_d;
  logic                   rw_q, rw_d;
  logic [1:0]             rd_idx_q, rd_idx_d;
  logic [RW-1:0]          snap_q, snap_d, result_q, result_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   addr_hit_q, addr_hit_d;
  logic [7:0]             last_cmd_q, last_cmd_d;
  logic                   data_valid_q, data_valid_d;
  logic                   powered_q, powered_d;
  logic                   meas_active_q, meas_active_d;
  logic                   one_shot_q, one_shot_d;
  logic [TW-1:0]          timer_q, timer_d;
`ifdef BH1750_CLK_STRETCH_EN
  logic                   stretch_q, stretch_d;
`endif

  logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic       addr_match, conv_done, cmd_stb;
  logic [7:0] rx_byte, cur_byte;
  logic [2:0] bit_dn;
  logic [7:0] rd_bytes [4];

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_prev_q;
  assign scl_fall   = ~scl_s & scl_prev_q;
  assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign rx_byte    = {shift_q, sda_s};
  assign addr_match = (rx_byte[7:1] == DEV_ADDR);
  assign conv_done  = meas_active_q && (timer_q == TIMER_LAST);
  assign bit_dn     = bit_cnt_q - 3'd1;
  assign cur_byte   = rd_bytes[rd_idx_q];

  // Byte 0 is the most significant byte of the snapshot; unused slots read as zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd
    if (gi < RD_BYTES) begin : g_used
      assign rd_bytes[gi] = snap_q[8*(RD_BYTES-1-gi) +: 8];
    end else begin : g_pad
      assign rd_bytes[gi] = 8'h00;
    end
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = S_ADDR;
    end else if (stop_det) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && bit_cnt_q == 3'd7 && !addr_match) state_d = S_IGNORE;
          else if (scl_fall && byte_done_q)                 state_d = S_ADDR_ACK;
        end
        S_ADDR_ACK: if (scl_fall) state_d = rw_q ? S_RD_BYTE : S_WR_BYTE;
        S_WR_BYTE:  if (scl_fall && byte_done_q) state_d = S_WR_ACK;
        S_WR_ACK:   if (scl_fall) state_d = S_WR_BYTE;
        S_RD_BYTE:  if (scl_fall && bit_cnt_q == 3'd0) state_d = S_RD_MACK;
        S_RD_MACK: begin
          if (scl_rise && sda_s)              state_d = S_IGNORE;
          else if (scl_fall && byte_done_q)   state_d = S_RD_BYTE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    scl_sync_d    = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
    sda_sync_d    = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    byte_done_d   = byte_done_q;
    rw_d          = rw_q;
    rd_idx_d      = rd_idx_q;
    snap_d        = snap_q;
    result_d      = result_q;
    sda_oe_d      = sda_oe_q;
    addr_hit_d    = 1'b0;
    last_cmd_d    = last_cmd_q;
    data_valid_d  = data_valid_q;
    powered_d     = powered_q;
    meas_active_d = meas_active_q;
    one_shot_d    = one_shot_q;
    timer_d       = timer_q;
    cmd_stb       = 1'b0;
`ifdef BH1750_CLK_STRETCH_EN
    stretch_d     = stretch_q;
`endif

    if (start_det || stop_det) begin
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && addr_match) begin
              byte_done_d = 1'b1;
              rw_d        = rx_byte[0];
              addr_hit_d  = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
            snap_d      = result_q;
`ifdef BH1750_CLK_STRETCH_EN
            if (rw_q && meas_active_q && !data_valid_q && !conv_done) stretch_d = 1'b1;
`endif
          end
        end
        S_ADDR_ACK: if (scl_fall) begin
          bit_cnt_d = 3'd0;
          rd_idx_d  = 2'd0;
          sda_oe_d  = 1'b0;
          if (rw_q) begin
            bit_cnt_d = 3'd7;
            sda_oe_d  = ~rd_bytes[0][7];
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              cmd_stb     = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            sda_oe_d    = 1'b1;
          end
        end
        S_WR_ACK: if (scl_fall) begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 3'd0;
        end
        S_RD_BYTE: if (scl_fall) begin
          if (bit_cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
          end else begin
            bit_cnt_d = bit_dn;
            sda_oe_d  = ~cur_byte[bit_dn];
          end
        end
        S_RD_MACK: begin
          if (scl_rise && !sda_s) begin
            byte_done_d = 1'b1;
            rd_idx_d    = (rd_idx_q == LAST_IDX) ? 2'd0 : rd_idx_q + 2'd1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = 3'd7;
            sda_oe_d    = ~cur_byte[7];
          end
        end
        default: ;
      endcase
    end

    if (meas_active_q) begin
      if (conv_done) begin
        timer_d      = '0;
        result_d     = meas_value;
        data_valid_d = 1'b1;
        if (one_shot_q) begin
          meas_active_d = 1'b0;
          powered_d     = 1'b0;
        end
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    // A command in the same cycle as a conversion end takes precedence.
    if (cmd_stb) begin
      last_cmd_d = rx_byte;
      casez (rx_byte)
        8'h00: begin
          powered_d     = 1'b0;
          meas_active_d = 1'b0;
        end
        8'h01: powered_d = 1'b1;
        8'h07: if (powered_q) begin
          result_d     = '0;
          data_valid_d = 1'b0;
        end
        8'b0001_00??, 8'b0010_00??: begin
          powered_d     = 1'b1;
          meas_active_d = 1'b1;
          one_shot_d    = rx_byte[5];
          timer_d       = '0;
        end
        default: ;
      endcase
    end

`ifdef BH1750_CLK_STRETCH_EN
    // The stalled read resumes with the freshly converted sample.
    if (stretch_q && conv_done) begin
      snap_d    = meas_value;
      stretch_d = 1'b0;
    end
    if (!meas_active_d) stretch_d = 1'b0;
`endif
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      scl_sync_q    <= '1;
      sda_sync_q    <= '1;
      scl_prev_q    <= 1'b1;
      sda_prev_q    <= 1'b1;
      bit_cnt_q     <= 3'd0;
      shift_q       <= '0;
      byte_done_q   <= 1'b0;
      rw_q          <= 1'b0;
      rd_idx_q      <= 2'd0;
      snap_q        <= '0;
      result_q      <= '0;
      sda_oe_q      <= 1'b0;
      addr_hit_q    <= 1'b0;
      last_cmd_q    <= 8'h00;
      data_valid_q  <= 1'b0;
      powered_q     <= 1'b0;
      meas_active_q <= 1'b0;
      one_shot_q    <= 1'b0;
      timer_q       <= '0;
`ifdef BH1750_CLK_STRETCH_EN
      stretch_q     <= 1'b0;
`endif
    end else begin
      scl_sync_q    <= scl_sync_d;
      sda_sync_q    <= sda_sync_d;
      scl_prev_q    <= scl_s;
      sda_prev_q    <= sda_s;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      byte_done_q   <= byte_done_d;
      rw_q          <= rw_d;
      rd_idx_q      <= rd_idx_d;
      snap_q        <= snap_d;
      result_q      <= result_d;
      sda_oe_q      <= sda_oe_d;
      addr_hit_q    <= addr_hit_d;
      last_cmd_q    <= last_cmd_d;
      data_valid_q  <= data_valid_d;
      powered_q     <= powered_d;
      meas_active_q <= meas_active_d;
      one_shot_q    <= one_shot_d;
      timer_q       <= timer_d;
`ifdef BH1750_CLK_STRETCH_EN
      stretch_q     <= stretch_d;
`endif
    end
  end

  assign bus.sda_oe = sda_oe_q;
`ifdef BH1750_CLK_STRETCH_EN
  assign bus.scl_oe = stretch_q;
`else
  assign bus.scl_oe = 1'b0;
`endif
  assign result     = result_q;
  assign data_valid = data_valid_q;
  assign powered    = powered_q;
  assign last_cmd   = last_cmd_q;
  assign addr_hit   = addr_hit_q;
endmodule

// File: tb/tb_bh1750_emul_param.sv
// Directed bench for bh1750_emul_param: open-drain bus master model plus a read-byte scoreboard.
module tb_bh1750_emul_param;
  localparam int MEAS = 400;
  localparam int H    = 8;
  localparam int LIM  = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        scl_drv = 1'b1;
  logic        sda_drv = 1'b1;
  logic [15:0] meas_value = 16'h1234;
  logic [15:0] result;
  logic        data_valid, powered, addr_hit;
  logic [7:0]  last_cmd;

  bh1750_emul_param_if bus();
  assign bus.scl_i = scl_drv & ~bus.scl_oe;
  assign bus.sda_i = sda_drv & ~bus.sda_oe;

  bh1750_emul_param #(
    .DEV_ADDR(7'h23), .RD_BYTES(2), .MEAS_CYCLES(MEAS), .SYNC_STAGES(2)
  ) dut (
    .system_clock(clk), .reset(rst), .bus(bus.slave), .meas_value(meas_value),
    .result(result), .data_valid(data_valid), .powered(powered),
    .last_cmd(last_cmd), .addr_hit(addr_hit)
  );

  int total = 0;
  int bad   = 0;
  int hits = 0, oe_cnt = 0, scl_oe_cnt = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] model_res = 16'h0000;

  always @(posedge clk) begin
    if (addr_hit === 1'b1)   hits++;
    if (bus.sda_oe === 1'b1) oe_cnt++;
    if (bus.scl_oe === 1'b1) scl_oe_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int n = 0;
    scl_drv = 1'b1;
    @(negedge clk);
    while (bus.scl_i !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIM) check("scl_release", 32'(bus.scl_i), 32'd1);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_cyc(H);
    scl_high();     wait_cyc(H);
    sda_drv = 1'b0; wait_cyc(H);
    scl_drv = 1'b0; wait_cyc(H);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_cyc(H);
    scl_high();     wait_cyc(H);
    sda_drv = 1'b1; wait_cyc(H);
  endtask

  task automatic clock_bit(input logic b, output logic r);
    sda_drv = b;
    wait_cyc(H);
    scl_high();
    wait_cyc(H / 2);
    r = bus.sda_i;
    wait_cyc(H / 2);
    scl_drv = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
    clock_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(~mack, r);
  endtask

  // Sends bytes[23:16], [15:8], [7:0] (first n of them) after the write address.
  task automatic write_txn(input logic [23:0] bytes, input int n);
    logic ack;
    logic [23:0] b;
    b = bytes;
    i2c_start();
    write_byte(8'h46, ack);
    check("wr_addr_ack", 32'(ack), 32'd1);
    for (int k = 0; k < n; k++) begin
      write_byte(b[23:16], ack);
      check($sformatf("cmd_ack_%02h", b[23:16]), 32'(ack), 32'd1);
      b = b << 8;
    end
    i2c_stop();
    $display("write txn: %0d byte(s) from %06h, last_cmd=%02h", n, bytes, last_cmd);
  endtask

  task automatic read_txn(input int n);
    logic ack;
    logic [7:0] d, e;
    for (int k = 0; k < n; k++) exp_q.push_back((k % 2 == 0) ? model_res[15:8] : model_res[7:0]);
    i2c_start();
    write_byte(8'h47, ack);
    check("rd_addr_ack", 32'(ack), 32'd1);
    for (int k = 0; k < n; k++) begin
      read_byte(k < n - 1, d);
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'(d), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rd_byte%0d", k), 32'(d), 32'(e));
      end
      $display("read byte %0d: %02h", k, d);
    end
    i2c_stop();
  endtask

  initial begin
    int h0, oe0, s0;
    logic ack, r;

    // Reset state
    wait_cyc(3);
    check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("rst_scl_oe", 32'(bus.scl_oe), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_powered", 32'(powered), 32'd0);
    check("rst_last_cmd", 32'(last_cmd), 32'd0);
    check("rst_addr_hit", 32'(addr_hit), 32'd0);
    rst = 1'b0;
    wait_cyc(4);

    // 1: continuous mode then read
    h0 = hits;
    meas_value = 16'h1234;
    write_txn({8'h10, 16'h0}, 1);
    check("t1_last_cmd", 32'(last_cmd), 32'h10);
    check("t1_powered", 32'(powered), 32'd1);
    wait_cyc(MEAS + 20);
    model_res = 16'h1234;
    check("t1_result", 32'(result), 32'h1234);
    check("t1_valid", 32'(data_valid), 32'd1);
    read_txn(2);
    check("t1_addr_hits", 32'(hits - h0), 32'd2);

    // 2: foreign address ignored, repeated START with own address accepted
    h0 = hits; oe0 = oe_cnt;
    i2c_start();
    write_byte(8'hB8, ack);
    check("t2_nack", 32'(ack), 32'd0);
    check("t2_sda_oe_idle", 32'(oe_cnt - oe0), 32'd0);
    check("t2_no_hit", 32'(hits - h0), 32'd0);
    read_txn(2);

    // 3: one-time mode
    meas_value = 16'hABCD;
    write_txn({8'h20, 16'h0}, 1);
    wait_cyc(MEAS + 20);
    check("t3_result", 32'(result), 32'hABCD);
    check("t3_valid", 32'(data_valid), 32'd1);
    check("t3_powered", 32'(powered), 32'd0);
    meas_value = 16'h5555;
    wait_cyc(MEAS + 20);
    check("t3_result_held", 32'(result), 32'hABCD);
    write_txn({8'h07, 16'h0}, 1);
    check("t3_rst_ignored", 32'(result), 32'hABCD);
    check("t3_last_cmd", 32'(last_cmd), 32'h07);

    // 4: read index wraps past RD_BYTES
    meas_value = 16'h1234;
    write_txn({8'h23, 16'h0}, 1);
    wait_cyc(MEAS + 20);
    model_res = 16'h1234;
    check("t4_result", 32'(result), 32'h1234);
    read_txn(3);

    // 5: reset while bit 4 of the first read byte is on the bus
    i2c_start();
    write_byte(8'h47, ack);
    check("t5_addr_ack", 32'(ack), 32'd1);
    for (int i = 7; i >= 5; i--) begin
      clock_bit(1'b1, r);
      check($sformatf("t5_bit%0d", i), 32'(r), 32'(model_res[8 + i]));
    end
    wait_cyc(6);
    rst = 1'b1;
    #1;
    check("t5_sda_oe_async", 32'(bus.sda_oe), 32'd0);
    wait_cyc(2);
    check("t5_result", 32'(result), 32'd0);
    check("t5_valid", 32'(data_valid), 32'd0);
    check("t5_last_cmd", 32'(last_cmd), 32'd0);
    check("t5_powered", 32'(powered), 32'd0);
    rst = 1'b0;
    model_res = 16'h0000;
    wait_cyc(4);
    i2c_stop();
    write_txn({8'h01, 16'h0}, 1);
    check("t5_powered_on", 32'(powered), 32'd1);
    check("t5_last_cmd_on", 32'(last_cmd), 32'h01);

    // 6: reset command while powered
    write_txn({8'h10, 16'h0}, 1);
    wait_cyc(MEAS + 20);
    check("t6_pre_result", 32'(result), 32'h1234);
    write_txn({8'h00, 8'h01, 8'h07}, 3);
    check("t6_result", 32'(result), 32'd0);
    check("t6_valid", 32'(data_valid), 32'd0);
    check("t6_powered", 32'(powered), 32'd1);
    check("t6_last_cmd", 32'(last_cmd), 32'h07);
`ifdef BH1750_CLK_STRETCH_EN
    s0 = scl_oe_cnt;
    write_txn({8'h10, 16'h0}, 1);
    wait_cyc(20);
    model_res = 16'h1234;
    read_txn(2);
    check("t6_stretched", 32'((scl_oe_cnt - s0) > 20), 32'd1);
`else
    s0 = 0;
    read_txn(2);
    check("t6_no_stretch", 32'(scl_oe_cnt - s0), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
